// File: rtl/defs_pkg.sv
// Shared types for the control unit: opcodes, FSM states, datapath select
// encodings and the control bundle that drives the datapath.
package defs_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_ADDI = 4'd6,
        OP_LDI  = 4'd7,
        OP_LD   = 4'd8,
        OP_ST   = 4'd9,
        OP_BR   = 4'd10,
        OP_JMP  = 4'd11,
        OP_JR   = 4'd12,
        OP_RSV  = 4'd13,
        OP_CMP  = 4'd14,
        OP_HALT = 4'd15
    } opcode_t;

    typedef enum logic [3:0] {
        S_FETCH0 = 4'd0,
        S_FETCH1 = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MADDR  = 4'd4,
        S_MREAD  = 4'd5,
        S_MLOAD  = 4'd6,
        S_MWRITE = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_WB     = 4'd10,
        S_HALT   = 4'd11
    } cu_state_t;

    // Condition codes 6..15 are never taken.
    typedef enum logic [3:0] {
        BR_ALWAYS = 4'd0,
        BR_Z      = 4'd1,
        BR_NZ     = 4'd2,
        BR_N      = 4'd3,
        BR_C      = 4'd4,
        BR_V      = 4'd5
    } br_cond_t;

    typedef enum logic       {PC_ADD = 1'b0, PC_AB = 1'b1} pc_sel_t;
    typedef enum logic [1:0] {ADDER_TWO = 2'd0, ADDER_IMM8 = 2'd1, ADDER_IMM12 = 2'd2} adder_sel_t;
    typedef enum logic       {REG2_HI = 1'b0, REG2_LO = 1'b1} reg2_sel_t;
    typedef enum logic [1:0] {REGW_ACC = 2'd0, REGW_IMM8 = 2'd1, REGW_MDR = 2'd2} regw_sel_t;
    typedef enum logic       {ALU_REG = 1'b0, ALU_IMM4 = 1'b1} alu_sel_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_load;
        logic       ab_load;
        logic       acc_load;
        logic       flag_load;
        logic       mar_load;
        logic       mdr_load;
        logic       mem_read;
        logic       mem_write;
        logic       rf_write;
        pc_sel_t    pc_sel;
        adder_sel_t adder_sel;
        reg2_sel_t  reg2_sel;
        regw_sel_t  regw_sel;
        alu_sel_t   alu_sel;
        opcode_t    alu_op;
    } ctrl_sig_t;

    localparam ctrl_sig_t CTRL_IDLE = '{
        pc_write:  1'b0, ir_load:   1'b0, ab_load:   1'b0, acc_load: 1'b0,
        flag_load: 1'b0, mar_load:  1'b0, mdr_load:  1'b0, mem_read: 1'b0,
        mem_write: 1'b0, rf_write:  1'b0,
        pc_sel:    PC_ADD, adder_sel: ADDER_TWO, reg2_sel: REG2_HI,
        regw_sel:  REGW_ACC, alu_sel: ALU_REG, alu_op: OP_NOP
    };

    // Opcodes that pass through EXEC (register ALU ops, ADDI, CMP).
    function automatic logic uses_exec(input opcode_t op);
        return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_CMP});
    endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluator: condition code plus registered ALU flags
// gives the taken decision. Purely combinational.
module branch_eval
    import defs_pkg::*;
(
    input  logic [3:0] cond,
    input  alu_flags_t flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            BR_ALWAYS: taken = 1'b1;
            BR_Z:      taken = flags.z;
            BR_NZ:     taken = ~flags.z;
            BR_N:      taken = flags.n;
            BR_C:      taken = flags.c;
            BR_V:      taken = flags.v;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the 16-opcode CPU. Outputs are decoded from the
// state register and IR opcode; only the branch PC write looks at the flags.
module control_unit
    import defs_pkg::*;
#(
    parameter int INSTR_WIDTH = 16,
    parameter int OPCODE_LSB  = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [INSTR_WIDTH-1:0] instruct,
    input  alu_flags_t             flags,
    output ctrl_sig_t              sigs,
    output logic                   halted,
    output logic                   instr_done
);

    cu_state_t state_reg;
    cu_state_t state_next;
    opcode_t   op;
    logic      br_taken;
    logic      unused_ir;

    assign op        = opcode_t'(instruct[OPCODE_LSB +: 4]);
    assign unused_ir = ^instruct;

    branch_eval u_branch_eval (
        .cond  (instruct[7:4]),
        .flags (flags),
        .taken (br_taken)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_FETCH0;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH0;
        case (state_reg)
            S_FETCH0: state_next = S_FETCH1;
            S_FETCH1: begin
                case (op)
                    OP_NOP, OP_RSV: state_next = S_FETCH0;
                    OP_LDI:         state_next = S_WB;
                    OP_BR, OP_JMP:  state_next = S_BRANCH;
                    OP_HALT:        state_next = S_HALT;
                    default:        state_next = S_DECODE;
                endcase
            end
            S_DECODE: begin
                if (uses_exec(op)) begin
                    state_next = S_EXEC;
                end else if (op == OP_LD || op == OP_ST) begin
                    state_next = S_MADDR;
                end else if (op == OP_JR) begin
                    state_next = S_JUMP;
                end else begin
                    state_next = S_FETCH0;
                end
            end
            S_EXEC:  state_next = (op == OP_CMP) ? S_FETCH0 : S_WB;
            S_MADDR: begin
                if (op == OP_ST) begin
                    state_next = S_MWRITE;
                end else if (op == OP_LD) begin
                    state_next = S_MREAD;
                end else begin
                    state_next = S_FETCH0;
                end
            end
            S_MREAD: state_next = S_MLOAD;
            S_MLOAD: state_next = S_WB;
            S_HALT:  state_next = S_HALT;
            // WB, MWRITE, BRANCH, JUMP end the instruction; illegal codes recover here too.
            default: state_next = S_FETCH0;
        endcase
    end

    always_comb begin
        sigs       = CTRL_IDLE;
        halted     = 1'b0;
        instr_done = 1'b0;
        case (state_reg)
            S_FETCH0: ;
            S_FETCH1: begin
                sigs.ir_load   = 1'b1;
                sigs.pc_write  = 1'b1;
                sigs.adder_sel = ADDER_TWO;
                sigs.pc_sel    = PC_ADD;
                instr_done     = (op == OP_NOP) || (op == OP_RSV);
            end
            S_DECODE: begin
                sigs.ab_load  = 1'b1;
                sigs.reg2_sel = REG2_HI;
            end
            S_EXEC: begin
                sigs.flag_load = 1'b1;
                sigs.acc_load  = (op != OP_CMP);
                sigs.alu_sel   = (op == OP_ADDI) ? ALU_IMM4 : ALU_REG;
                case (op)
                    OP_ADDI: sigs.alu_op = OP_ADD;
                    OP_CMP:  sigs.alu_op = OP_SUB;
                    default: sigs.alu_op = op;
                endcase
                instr_done = (op == OP_CMP);
            end
            S_MADDR: begin
                sigs.mar_load = 1'b1;
                // A store reloads B from rd so MWRITE sees the data register.
                if (op == OP_ST) begin
                    sigs.ab_load  = 1'b1;
                    sigs.reg2_sel = REG2_LO;
                end
            end
            S_MREAD: sigs.mem_read = 1'b1;
            S_MLOAD: sigs.mdr_load = 1'b1;
            S_MWRITE: begin
                sigs.mem_write = 1'b1;
                instr_done     = 1'b1;
            end
            S_BRANCH: begin
                if (op == OP_JMP) begin
                    sigs.adder_sel = ADDER_IMM12;
                    sigs.pc_write  = 1'b1;
                end else begin
                    sigs.adder_sel = ADDER_IMM8;
                    sigs.pc_write  = br_taken;
                end
                instr_done = 1'b1;
            end
            S_JUMP: begin
                sigs.pc_write = 1'b1;
                sigs.pc_sel   = PC_AB;
                instr_done    = 1'b1;
            end
            S_WB: begin
                sigs.rf_write = 1'b1;
                case (op)
                    OP_LDI:  sigs.regw_sel = REGW_IMM8;
                    OP_LD:   sigs.regw_sel = REGW_MDR;
                    default: sigs.regw_sel = REGW_ACC;
                endcase
                instr_done = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a per-opcode micro-op table model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_control_unit;
    import defs_pkg::*;

    localparam int HALT_CYCLES = 20;

    logic        clk;
    logic        resetn;
    logic [15:0] instruct;
    alu_flags_t  flags;
    ctrl_sig_t   sigs;
    logic        halted;
    logic        instr_done;

    int tests = 0;
    int fails = 0;

    bit        exp_valid = 1'b0;
    ctrl_sig_t exp_sigs;
    logic      exp_halted;
    logic      exp_done;
    int        cur_k = -1;
    bit        cycle_open = 1'b0;

    ctrl_sig_t obs_sigs   [0:31];
    logic      obs_done   [0:31];
    logic      obs_halted [0:31];

    control_unit #(.INSTR_WIDTH(16), .OPCODE_LSB(0)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .instruct   (instruct),
        .flags      (flags),
        .sigs       (sigs),
        .halted     (halted),
        .instr_done (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (k=%0d, t=%0t)", name, got, expv, cur_k, $time);
        end
    endtask

    function automatic logic [31:0] sw(input ctrl_sig_t s);
        logic [31:0] r;
        r = '0;
        r[$bits(ctrl_sig_t)-1:0] = s;
        return r;
    endfunction

    // Number of cycles an instruction occupies, FETCH0 included.
    function automatic int model_len(input logic [3:0] op);
        case (op)
            4'd0, 4'd13:                     return 2;
            4'd7, 4'd10, 4'd11:              return 3;
            4'd12, 4'd14:                    return 4;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
            4'd6, 4'd9:                      return 5;
            4'd8:                            return 7;
            default:                         return 2 + HALT_CYCLES;
        endcase
    endfunction

    // Expected control bundle for cycle k of instruction ir under flags f.
    function automatic ctrl_sig_t model_sigs(input logic [15:0] ir, input int k, input alu_flags_t f);
        ctrl_sig_t  s;
        logic [3:0] op;
        logic [3:0] cond;
        logic [5:0] cvec;
        s    = CTRL_IDLE;
        op   = ir[3:0];
        cond = ir[7:4];
        cvec = {f.v, f.c, f.n, ~f.z, f.z, 1'b1};
        if (k == 1) begin
            s.ir_load  = 1'b1;
            s.pc_write = 1'b1;
        end else if (k >= 2) begin
            case (op)
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd14: begin
                    if (k == 2) s.ab_load = 1'b1;
                    if (k == 3) begin
                        s.flag_load = 1'b1;
                        s.acc_load  = (op != 4'd14);
                        s.alu_sel   = (op == 4'd6) ? ALU_IMM4 : ALU_REG;
                        s.alu_op    = (op == 4'd6) ? OP_ADD : (op == 4'd14) ? OP_SUB : opcode_t'(op);
                    end
                    if (k == 4) s.rf_write = 1'b1;
                end
                4'd7: begin
                    s.rf_write = 1'b1;
                    s.regw_sel = REGW_IMM8;
                end
                4'd8: begin
                    if (k == 2) s.ab_load  = 1'b1;
                    if (k == 3) s.mar_load = 1'b1;
                    if (k == 4) s.mem_read = 1'b1;
                    if (k == 5) s.mdr_load = 1'b1;
                    if (k == 6) begin
                        s.rf_write = 1'b1;
                        s.regw_sel = REGW_MDR;
                    end
                end
                4'd9: begin
                    if (k == 2) s.ab_load = 1'b1;
                    if (k == 3) begin
                        s.mar_load = 1'b1;
                        s.ab_load  = 1'b1;
                        s.reg2_sel = REG2_LO;
                    end
                    if (k == 4) s.mem_write = 1'b1;
                end
                4'd10: begin
                    s.adder_sel = ADDER_IMM8;
                    s.pc_write  = (cond < 4'd6) ? cvec[cond[2:0]] : 1'b0;
                end
                4'd11: begin
                    s.adder_sel = ADDER_IMM12;
                    s.pc_write  = 1'b1;
                end
                4'd12: begin
                    if (k == 2) s.ab_load = 1'b1;
                    if (k == 3) begin
                        s.pc_write = 1'b1;
                        s.pc_sel   = PC_AB;
                    end
                end
                default: ;
            endcase
        end
        return s;
    endfunction

    // Single compare process: every cycle with a live expectation.
    always @(negedge clk) begin
        if (exp_valid) begin
            check("sigs", sw(sigs), sw(exp_sigs));
            check("halted", {31'b0, halted}, {31'b0, exp_halted});
            check("instr_done", {31'b0, instr_done}, {31'b0, exp_done});
            if (cur_k >= 0 && cur_k < 32) begin
                obs_sigs[cur_k]   = sigs;
                obs_done[cur_k]   = instr_done;
                obs_halted[cur_k] = halted;
            end
        end
    end

    task automatic cycle_begin();
        if (cycle_open) begin
            cycle_open = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_exp_reset();
        exp_sigs   = CTRL_IDLE;
        exp_halted = 1'b0;
        exp_done   = 1'b0;
        cur_k      = -1;
        exp_valid  = 1'b1;
    endtask

    // Hold reset for n cycles, then release it just after an edge so the
    // following instruction starts in that same cycle at FETCH0.
    task automatic do_reset(input int n);
        cycle_begin();
        resetn = 1'b0;
        set_exp_reset();
        repeat (n) cycle_begin();
        cycle_begin();
        resetn     = 1'b1;
        cycle_open = 1'b1;
    endtask

    task automatic run_instr(input logic [15:0] ir, input int abort_at,
                             input bit fix_flags, input alu_flags_t fflags);
        int len;
        len = model_len(ir[3:0]);
        for (int k = 0; k < len; k++) begin
            cycle_begin();
            instruct   = ir;
            flags      = fix_flags ? fflags : alu_flags_t'($urandom_range(0, 15));
            cur_k      = k;
            exp_sigs   = model_sigs(ir, k, flags);
            exp_halted = (ir[3:0] == 4'd15) && (k >= 2);
            exp_done   = (ir[3:0] != 4'd15) && (k == len - 1);
            exp_valid  = 1'b1;
            if (k == abort_at) begin
                @(negedge clk);
                #1;
                resetn = 1'b0;
                #1;
                check("abort_mem_write", {31'b0, sigs.mem_write}, 32'd0);
                check("abort_sigs_idle", sw(sigs), 32'd0);
                check("abort_halted", {31'b0, halted}, 32'd0);
                set_exp_reset();
                return;
            end
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ir;
        int          ab;
        resetn   = 1'b0;
        instruct = 16'h0001;
        flags    = '0;

        // Reset with ADD held in the IR.
        do_reset(3);
        run_instr(16'h0001, -1, 1'b0, '0);
        check("rst_first_idle", sw(obs_sigs[0]), 32'd0);
        check("rst_ir_load", {31'b0, obs_sigs[1].ir_load}, 32'd1);
        check("rst_pc_write", {31'b0, obs_sigs[1].pc_write}, 32'd1);

        // OR r3,r2 -> r1
        run_instr(16'h3214, -1, 1'b0, '0);
        check("or_ab_load", {31'b0, obs_sigs[2].ab_load}, 32'd1);
        check("or_alu_op", 32'(obs_sigs[3].alu_op), 32'd4);
        check("or_acc_flag", {30'b0, obs_sigs[3].acc_load, obs_sigs[3].flag_load}, 32'd3);
        check("or_rf_write", {31'b0, obs_sigs[4].rf_write}, 32'd1);
        check("or_regw", 32'(obs_sigs[4].regw_sel), 32'd0);
        check("or_done_c5", {31'b0, obs_done[4]}, 32'd1);

        // LD r0 <- [{r1,r2}]
        run_instr(16'h1208, -1, 1'b0, '0);
        check("ld_mem_read", {31'b0, obs_sigs[4].mem_read}, 32'd1);
        check("ld_mdr_load", {31'b0, obs_sigs[5].mdr_load}, 32'd1);
        check("ld_regw_mdr", 32'(obs_sigs[6].regw_sel), 32'd2);
        check("ld_done_c7", {31'b0, obs_done[6]}, 32'd1);

        // BR Z,-2 taken and not taken.
        run_instr(16'hFE1A, -1, 1'b1, 4'b1000);
        check("brz_taken_pcw", {31'b0, obs_sigs[2].pc_write}, 32'd1);
        check("brz_adder_imm8", 32'(obs_sigs[2].adder_sel), 32'd1);
        check("brz_taken_done", {31'b0, obs_done[2]}, 32'd1);
        run_instr(16'hFE1A, -1, 1'b1, 4'b0111);
        check("brz_not_taken_pcw", {31'b0, obs_sigs[2].pc_write}, 32'd0);
        check("brz_not_taken_done", {31'b0, obs_done[2]}, 32'd1);

        // HALT, then reset out of it.
        run_instr(16'h000F, -1, 1'b0, '0);
        check("halt_c3", {31'b0, obs_halted[2]}, 32'd1);
        check("halt_last", sw(obs_sigs[HALT_CYCLES + 1]), 32'd0);
        do_reset(2);

        // Reset during MWRITE of a store.
        run_instr(16'h0219, 4, 1'b0, '0);
        check("st_mem_write_before_abort", {31'b0, obs_sigs[4].mem_write}, 32'd1);
        do_reset(2);
        run_instr(16'h0219, -1, 1'b0, '0);
        check("st_restart_done", {31'b0, obs_done[4]}, 32'd1);

        // Randomized instruction stream with occasional aborts and halts.
        for (int n = 0; n < 400; n++) begin
            ir = 16'($urandom);
            if (ir[3:0] == 4'd15 && $urandom_range(0, 3) != 0)
                ir[3:0] = 4'($urandom_range(0, 14));
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, model_len(ir[3:0]) - 1) : -1;
            run_instr(ir, ab, 1'b0, '0);
            if (ab >= 0 || ir[3:0] == 4'd15)
                do_reset($urandom_range(1, 3));
        end

        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
